// File: rtl/clk_mode_ctrl_if.sv
// Mode-request handshake between a requester and the clock mode sequencer.
interface clk_mode_ctrl_if;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;

  modport master (output req_valid, output req_mode, input req_ready);
  modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/clk_mode_ctrl.sv
// Clock generator mode sequencer: gate, switch en, settle, confirm against which_clk.
// state  | meaning
// IDLE   | waiting for a request, gate open
// GATE   | downstream gated, draining before en changes
// SETTLE | en changed, waiting for dividers to restart
// CHECK  | comparing which_clk against en, bounded by timeout
// DONE   | one-cycle completion pulse, cur_mode updated
// FAULT  | feedback never matched, waiting for err_clr
module clk_mode_ctrl #(
  parameter int DRAIN_CYC   = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  clk_mode_ctrl_if.slave   req,
  input  logic [1:0]       which_clk,
  output logic [1:0]       en,
  output logic             gate_en,
  output logic [1:0]       cur_mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam int SETTLE_W  = $clog2(SETTLE_CYC + 1);
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DRAIN_W-1:0]   DRAIN_LAST   = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GATE, S_SETTLE, S_CHECK, S_DONE, S_FAULT
  } state_t;

  state_t                state, state_nx;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [TIMEOUT_W-1:0]  timeout_cnt;
  logic [1:0]            tgt_mode, tgt_d;
  logic [1:0]            en_d, cur_mode_d;
  logic                  gate_en_d, busy_d, done_d, err_d;
  logic                  accept, fb_match;

  assign req.req_ready = (state == S_IDLE);
  assign accept        = (state == S_IDLE) && req.req_valid;
  assign fb_match      = (which_clk == en);

  // Counters clear whenever the state changes, so each one starts at 0 on entry.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state       <= S_IDLE;
      tgt_mode    <= 2'b00;
      drain_cnt   <= '0;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      state       <= state_nx;
      tgt_mode    <= tgt_d;
      drain_cnt   <= (state == S_GATE && state_nx == S_GATE)
                     ? drain_cnt + DRAIN_W'(1) : '0;
      settle_cnt  <= (state == S_SETTLE && state_nx == S_SETTLE)
                     ? settle_cnt + SETTLE_W'(1) : '0;
      timeout_cnt <= (state == S_CHECK && state_nx == S_CHECK)
                     ? timeout_cnt + TIMEOUT_W'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req.req_valid)
                  state_nx = (req.req_mode == cur_mode) ? S_DONE : S_GATE;
      S_GATE:   if (drain_cnt == DRAIN_LAST) state_nx = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = S_CHECK;
      S_CHECK: begin
        // A match on the final CHECK cycle takes priority over the timeout.
        if (fb_match)                          state_nx = S_DONE;
        else if (timeout_cnt == TIMEOUT_LAST)  state_nx = S_FAULT;
      end
      S_DONE:   state_nx = S_IDLE;
      S_FAULT:  if (err_clr) state_nx = S_SETTLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tgt_d      = tgt_mode;
    en_d       = en;
    cur_mode_d = cur_mode;
    if (accept) tgt_d = req.req_mode;
    if (state == S_GATE && drain_cnt == DRAIN_LAST) en_d = tgt_mode;
    if (state == S_FAULT && err_clr) begin
      en_d  = cur_mode;
      tgt_d = cur_mode;
    end
    if (state_nx == S_DONE) cur_mode_d = tgt_d;
    gate_en_d = (state_nx == S_IDLE) || (state_nx == S_DONE);
    busy_d    = (state_nx == S_GATE) || (state_nx == S_SETTLE) || (state_nx == S_CHECK);
    done_d    = (state_nx == S_DONE);
    err_d     = (state_nx == S_FAULT);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      en       <= 2'b00;
      cur_mode <= 2'b00;
      gate_en  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      en       <= en_d;
      cur_mode <= cur_mode_d;
      gate_en  <= gate_en_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule
